// File: rtl/csc_pipe.sv
// csc_pipe: three-stage, backpressured RGB<->YCbCr (BT.601 studio range) converter.
// Pixel, mode and sideband move together; the whole pipe stalls only on a held output.
module csc_pipe #(
    parameter int DW = 8,
    parameter int UW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_mode,
    input  logic [3*DW-1:0] s_data,
    input  logic [UW-1:0]   s_user,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [3*DW-1:0] m_data,
    output logic [UW-1:0]   m_user,
    output logic            m_mode
);

    localparam int S  = DW - 8;
    localparam int PW = DW + 14;

    localparam logic signed [PW-1:0] OFF16  = PW'(16 << S);
    localparam logic signed [PW-1:0] OFF128 = PW'(128 << S);
    localparam logic signed [PW-1:0] RND    = PW'(128);
    localparam logic signed [PW-1:0] MAXV   = PW'((1 << DW) - 1);

    function automatic logic signed [PW-1:0] mul(
        input logic signed [PW-1:0] x,
        input int                   k
    );
        return x * PW'(k);
    endfunction

    function automatic logic [DW-1:0] sat(input logic signed [PW-1:0] x);
        logic [DW-1:0] r;
        if (x < 0)
            r = '0;
        else if (x > MAXV)
            r = '1;
        else
            r = x[DW-1:0];
        return r;
    endfunction

    logic en;
    assign en      = !m_valid || m_ready;
    assign s_ready = en;

    logic            v1;
    logic            mode1;
    logic [UW-1:0]   user1;
    logic [3*DW-1:0] d1;

    logic                   v2;
    logic                   mode2;
    logic [UW-1:0]          user2;
    logic signed [PW-1:0]   p2 [9];

    logic signed [PW-1:0] x0, x1, x2;
    logic signed [PW-1:0] p [9];

    // Inverse mode removes the studio offsets before the multiplies.
    always_comb begin
        x0 = PW'(d1[3*DW-1:2*DW]);
        x1 = PW'(d1[2*DW-1:DW]);
        x2 = PW'(d1[DW-1:0]);
        if (mode1) begin
            x0 = x0 - OFF16;
            x1 = x1 - OFF128;
            x2 = x2 - OFF128;
        end
        for (int i = 0; i < 9; i++)
            p[i] = '0;
        if (!mode1) begin
            p[0] = mul(x0, 66);
            p[1] = mul(x1, 129);
            p[2] = mul(x2, 25);
            p[3] = mul(x0, -38);
            p[4] = mul(x1, -74);
            p[5] = mul(x2, 112);
            p[6] = mul(x0, 112);
            p[7] = mul(x1, -94);
            p[8] = mul(x2, -18);
        end else begin
            p[0] = mul(x0, 298);
            p[1] = '0;
            p[2] = mul(x2, 409);
            p[3] = mul(x0, 298);
            p[4] = mul(x1, -100);
            p[5] = mul(x2, -208);
            p[6] = mul(x0, 298);
            p[7] = mul(x1, 516);
            p[8] = '0;
        end
    end

    logic signed [PW-1:0] t [3];
    logic [DW-1:0]        q [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            t[i] = (p2[3*i] + p2[3*i+1] + p2[3*i+2] + RND) >>> 8;
            if (!mode2)
                t[i] = t[i] + ((i == 0) ? OFF16 : OFF128);
            q[i] = sat(t[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            mode1   <= 1'b0;
            user1   <= '0;
            d1      <= '0;
            v2      <= 1'b0;
            mode2   <= 1'b0;
            user2   <= '0;
            p2      <= '{default: '0};
            m_valid <= 1'b0;
            m_data  <= '0;
            m_user  <= '0;
            m_mode  <= 1'b0;
        end else if (en) begin
            v1      <= s_valid;
            mode1   <= s_mode;
            user1   <= s_user;
            d1      <= s_data;
            v2      <= v1;
            mode2   <= mode1;
            user2   <= user1;
            p2      <= p;
            m_valid <= v2;
            m_data  <= {q[0], q[1], q[2]};
            m_user  <= user2;
            m_mode  <= mode2;
        end
    end

endmodule

// File: tb/tb_csc_pipe.sv
// tb_csc_pipe: random and directed pixels through DW=8 and DW=10 converters,
// scoreboarded against an integer model of the conversion equations.
module tb_csc_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_mode = 1'b0;
    logic [1:0]  s_user = '0;
    logic [23:0] s_data8 = '0;
    logic [29:0] s_data10 = '0;
    logic        m_ready = 1'b1;

    logic        s_ready8, m_valid8, m_mode8;
    logic [1:0]  m_user8;
    logic [23:0] m_data8;
    logic        s_ready10, m_valid10, m_mode10;
    logic [1:0]  m_user10;
    logic [29:0] m_data10;

    always #5 clk = ~clk;

    csc_pipe #(.DW(8), .UW(2)) dut8 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready8), .s_mode(s_mode),
        .s_data(s_data8), .s_user(s_user),
        .m_valid(m_valid8), .m_ready(m_ready), .m_data(m_data8),
        .m_user(m_user8), .m_mode(m_mode8)
    );

    csc_pipe #(.DW(10), .UW(2)) dut10 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready10), .s_mode(s_mode),
        .s_data(s_data10), .s_user(s_user),
        .m_valid(m_valid10), .m_ready(m_ready), .m_data(m_data10),
        .m_user(m_user10), .m_mode(m_mode10)
    );

    int compared = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int x, input int dw);
        int mx;
        mx = (1 << dw) - 1;
        return (x < 0) ? 0 : ((x > mx) ? mx : x);
    endfunction

    // Returns {c0,c1,c2} as three 12-bit fields.
    function automatic logic [35:0] conv(input int dw, input bit md, input int a, input int b, input int c);
        int s, o16, o128, r0, r1, r2, y, u, v;
        s = dw - 8;
        o16 = 16 << s;
        o128 = 128 << s;
        if (!md) begin
            r0 = ((66*a + 129*b + 25*c + 128) >>> 8) + o16;
            r1 = ((-38*a - 74*b + 112*c + 128) >>> 8) + o128;
            r2 = ((112*a - 94*b - 18*c + 128) >>> 8) + o128;
        end else begin
            y = a - o16;
            u = b - o128;
            v = c - o128;
            r0 = (298*y + 409*v + 128) >>> 8;
            r1 = (298*y - 100*u - 208*v + 128) >>> 8;
            r2 = (298*y + 516*u + 128) >>> 8;
        end
        return {12'(sat(r0, dw)), 12'(sat(r1, dw)), 12'(sat(r2, dw))};
    endfunction

    function automatic logic [23:0] pk8(input logic [35:0] r);
        return {r[31:24], r[19:12], r[7:0]};
    endfunction

    function automatic logic [29:0] pk10(input logic [35:0] r);
        return {r[33:24], r[21:12], r[9:0]};
    endfunction

    typedef struct {
        logic [23:0] e8;
        logic [29:0] e10;
        logic        md;
        logic [1:0]  us;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    bit   lat_chk = 1'b1;
    bit   rand_ready = 1'b0;
    bit   prev_stall = 1'b0;
    logic [26:0] prev_out = '0;

    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        logic [35:0] r8, r10;
        if (!rst) begin
            cyc++;
            chk("s_ready8", 64'(s_ready8), 64'(!(m_valid8 && !m_ready)));
            chk("s_ready10", 64'(s_ready10), 64'(!(m_valid8 && !m_ready)));
            if (prev_stall)
                chk("stall_hold", 64'({m_data8, m_user8, m_mode8}), 64'(prev_out));
            if (s_valid && s_ready8) begin
                r8  = conv(8, s_mode, int'(s_data8[23:16]), int'(s_data8[15:8]), int'(s_data8[7:0]));
                r10 = conv(10, s_mode, int'(s_data10[29:20]), int'(s_data10[19:10]), int'(s_data10[9:0]));
                e.e8 = pk8(r8);
                e.e10 = pk10(r10);
                e.md = s_mode;
                e.us = s_user;
                e.cyc = cyc;
                sb.push_back(e);
            end
            if (m_valid8 && m_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious", 64'(m_valid8), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("data8", 64'(m_data8), 64'(e.e8));
                    chk("data10", 64'(m_data10), 64'(e.e10));
                    chk("valid10", 64'(m_valid10), 64'(1));
                    chk("mode", 64'({m_mode8, m_mode10}), 64'({e.md, e.md}));
                    chk("user", 64'({m_user8, m_user10}), 64'({e.us, e.us}));
                    if (lat_chk)
                        chk("latency", 64'(cyc - e.cyc), 64'(3));
                end
            end
            prev_stall = m_valid8 && !m_ready;
            prev_out = {m_data8, m_user8, m_mode8};
        end
    end

    task automatic beat(input bit md, input logic [23:0] d8, input logic [29:0] d10, input logic [1:0] us);
        bit done;
        done = 1'b0;
        s_valid = 1'b1;
        s_mode = md;
        s_data8 = d8;
        s_data10 = d10;
        s_user = us;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            done = s_ready8;
            #1;
        end
        if (!done)
            chk("accept_timeout", 64'(0), 64'(1));
        s_valid = 1'b0;
    endtask

    task automatic rbeat(input bit md);
        beat(md, 24'($urandom), 30'($urandom), 2'($urandom));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || m_valid8) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300)
            chk("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        chk("m0_black", 64'(pk8(conv(8, 0, 0, 0, 0))), 64'({8'd16, 8'd128, 8'd128}));
        chk("m0_white", 64'(pk8(conv(8, 0, 255, 255, 255))), 64'({8'd235, 8'd128, 8'd128}));
        chk("m0_red", 64'(pk8(conv(8, 0, 255, 0, 0))), 64'({8'd82, 8'd90, 8'd240}));
        chk("m1_white", 64'(pk8(conv(8, 1, 235, 128, 128))), 64'({8'd255, 8'd255, 8'd255}));
        chk("m1_red", 64'(pk8(conv(8, 1, 16, 128, 240))), 64'({8'd179, 8'd0, 8'd0}));
        chk("m1_clamp", 64'(pk8(conv(8, 1, 255, 255, 255))), 64'({8'd255, 8'd125, 8'd255}));
        chk("m0_black10", 64'(pk10(conv(10, 0, 0, 0, 0))), 64'({10'd64, 10'd512, 10'd512}));

        #12;
        chk("rst_out8", 64'({m_valid8, m_data8, m_user8, m_mode8}), 64'(0));
        chk("rst_out10", 64'({m_valid10, m_data10, m_user10, m_mode10}), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rst_ready", 64'({s_ready8, s_ready10}), 64'(2'b11));

        // directed pixels, isolated, then back-to-back
        beat(0, {8'd0, 8'd0, 8'd0}, 30'd0, 2'd1);
        beat(0, {8'd255, 8'd255, 8'd255}, {10'd1023, 10'd1023, 10'd1023}, 2'd2);
        repeat (4) @(posedge clk);
        #1;
        beat(0, {8'd255, 8'd0, 8'd0}, {10'd1023, 10'd0, 10'd0}, 2'd3);
        beat(1, {8'd235, 8'd128, 8'd128}, {10'd940, 10'd512, 10'd512}, 2'd0);
        beat(1, {8'd16, 8'd128, 8'd240}, {10'd64, 10'd512, 10'd960}, 2'd1);
        beat(1, {8'd255, 8'd255, 8'd255}, {10'd1023, 10'd1023, 10'd1023}, 2'd2);
        drain();

        for (int i = 0; i < 50; i++)
            rbeat(i[0]);
        drain();

        lat_chk = 1'b0;
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            rbeat(1'($urandom));
        end
        rand_ready = 1'b0;
        drain();
        lat_chk = 1'b1;

        // reset with pixels in flight
        rbeat(0);
        rbeat(1);
        rbeat(0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 64'({m_valid8, m_valid10}), 64'(0));
        chk("midrst_data", 64'({m_data8, m_user8, m_mode8}), 64'(0));
        sb.delete();
        prev_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_idle", 64'(m_valid8), 64'(0));
        for (int i = 0; i < 10; i++)
            rbeat(1'($urandom));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
